div_32_seq: RTL



---
 rtl/div_32_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/div_32_seq.sv
// Multicycle restoring divider for MIPS32 DIV/DIVU: one quotient bit per cycle,
// with sign fix-up and divide-by-zero handling before the results reach HI/LO.
module div_32_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             sdvd_q, sdvd_d;
  logic             sdvs_q, sdvs_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbzo_q, dbzo_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    sdvd_d  = sdvd_q;
    sdvs_d  = sdvs_q;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbzo_d  = dbzo_q;

    // WIDTH+1-bit trial subtraction; borrow marks a negative trial.
    shifted          = {rem_q, q_q[WIDTH-1]};
    {borrow, diff}   = {1'b0, shifted} - {2'b00, dvs_q};

    case (state_q)
      StIdle: begin
        if (start) begin
          sdvd_d  = is_signed & dividend[WIDTH-1];
          sdvs_d  = is_signed & divisor[WIDTH-1];
          q_d     = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d   = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
          dvd_d   = dividend;
          dbz_d   = (divisor == '0);
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StFix: begin
        if (dbz_q) begin
          quot_d = '1;
          remo_d = dvd_q;
          dbzo_d = 1'b1;
        end else begin
          quot_d = (sdvd_q ^ sdvs_q) ? -q_q : q_q;
          remo_d = sdvd_q ? -rem_q : rem_q;
          dbzo_d = 1'b0;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      sdvd_q  <= 1'b0;
      sdvs_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbzo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      sdvd_q  <= sdvd_d;
      sdvs_q  <= sdvs_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbzo_q  <= dbzo_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbzo_q;

endmodule
